// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

  // One buffered fetch result: the word and the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Instruction addresses are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Small registered FIFO of fetch entries with a synchronous flush.
// Flush wins over push/pop in the same cycle. Output is the registered head,
// so there is no combinational path from i_push to o_head.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  fetch_entry_t      i_entry,
  input  logic              i_pop,
  input  logic              i_flush,
  output fetch_entry_t      o_head,
  output logic [CW-1:0]     o_count,
  output logic              o_empty,
  output logic              o_full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == PW'(DEPTH - 1)) return '0;
    return ptr + PW'(1);
  endfunction

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // Storage: written on push, no reset needed since count gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  // Pointer and occupancy tracking; flush empties the queue in one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// RV32I instruction fetch stage.
// Memory side: req/gnt/rvalid. A request is accepted on req && gnt; exactly
// one rvalid comes back per accepted request, in order, no earlier than the
// cycle after the grant.
// Decode side: valid/ready. An entry transfers on instr_valid_o &&
// instr_ready_i; instr_o/pc_o hold steady while valid is high and not accepted,
// except that a redirect masks valid in its own cycle.
// Credit rule: queued entries plus outstanding requests never exceed DEPTH, so
// a returning word always has a free slot.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   r_pc;           // next address to request
  logic [31:0]   r_resp_pc;      // PC of the next response to be kept
  logic [CW-1:0] r_outstanding;  // granted requests without rvalid yet
  logic [CW-1:0] r_discard;      // wrong-path responses still to drop

  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  fetch_entry_t  w_head;
  fetch_entry_t  w_new_entry;
  logic [CW:0]   w_inflight;
  logic          w_credit;
  logic          w_req;
  logic          w_grant;
  logic          w_keep;
  logic          w_drop;
  logic          w_valid;
  logic          w_pop;
  logic [31:0]   w_target;

  assign w_inflight = {1'b0, w_count} + {1'b0, r_outstanding};
  assign w_credit   = (w_inflight < (CW + 1)'(DEPTH));
  // Reset gating keeps req low while rst_ni is asserted.
  assign w_req      = rst_ni && !redirect_i && w_credit;
  assign w_grant    = w_req && imem_gnt_i;

  // A response in a redirect cycle is always dropped; otherwise discard decides.
  assign w_keep = imem_rvalid_i && !redirect_i && (r_discard == '0);
  assign w_drop = imem_rvalid_i && !redirect_i && (r_discard != '0);

  assign w_valid  = !w_empty && !redirect_i;
  assign w_pop    = w_valid && instr_ready_i;
  assign w_target = word_align(redirect_pc_i);

  assign w_new_entry.pc    = r_resp_pc;
  assign w_new_entry.instr = imem_rdata_i;

  ifu_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (w_keep),
    .i_entry (w_new_entry),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // PC tracking: request PC advances per grant, response PC per kept word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
    end else if (redirect_i) begin
      r_pc      <= w_target;
      r_resp_pc <= w_target;
    end else begin
      if (w_grant) r_pc      <= r_pc + 32'd4;
      if (w_keep)  r_resp_pc <= r_resp_pc + 32'd4;
    end
  end

  // In-flight accounting: every response still due at a redirect is wrong-path.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (redirect_i) begin
      // No grant is possible in a redirect cycle, so only rvalid retires one.
      r_outstanding <= r_outstanding - CW'(imem_rvalid_i);
      r_discard     <= r_outstanding - CW'(imem_rvalid_i);
    end else begin
      unique case ({w_grant, imem_rvalid_i})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_drop) r_discard <= r_discard - CW'(1);
    end
  end

  assign imem_req_o    = w_req;
  assign imem_addr_o   = r_pc;
  assign instr_valid_o = w_valid;
  assign instr_o       = w_valid ? w_head.instr : NOP_INSTR;
  assign pc_o          = w_valid ? w_head.pc : 32'h0;

  // w_full is informative only; the credit rule already prevents overflow.
  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed vector table, then randomized traffic
// against a transaction-level reference model.
module tb_ifu_fetch;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] rpc;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  ifu_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (rpc),
    .instr_valid_o (valid),
    .instr_ready_i (ready),
    .instr_o       (instr),
    .pc_o          (pc)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents as a function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic idle_inputs();
    gnt = 0; rvalid = 0; rdata = '0; redirect = 0; rpc = '0; ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc",    pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Driver: apply one cycle of inputs at the falling edge and let outputs settle.
  task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdir, input logic [31:0] tgt, input logic rdy);
    @(negedge clk);
    cyc++;
    gnt = g; rvalid = rv; rdata = rd; redirect = rdir; rpc = tgt; ready = rdy;
    #1;
  endtask

  // Directed vector table
  typedef struct {
    logic        g;
    logic        rv;
    logic [31:0] rd;
    logic        rdir;
    logic [31:0] tgt;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd_addr,
                              input logic rdir, input logic [31:0] tgt, input logic rdy,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc);
    vec_t v;
    v.g = g; v.rv = rv; v.rd = rv ? mem_word(rd_addr) : 32'hDEAD_BEEF;
    v.rdir = rdir; v.tgt = tgt; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pc    = e_valid ? e_pc : 32'h0;
    v.e_instr = e_valid ? mem_word(e_pc) : NOP;
    return v;
  endfunction

  task automatic run_table();
    //            g  rv rd_addr       rdir tgt           rdy  req addr          v  pc
    tbl[0]  = mk(1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0,        0, 32'h0);
    tbl[1]  = mk(1, 1, 32'h0,        0, 32'h0,        1,   1, 32'h4,        0, 32'h0);
    tbl[2]  = mk(0, 1, 32'h4,        0, 32'h0,        0,   0, 32'h8,        1, 32'h0);
    tbl[3]  = mk(0, 0, 32'h0,        0, 32'h0,        0,   0, 32'h8,        1, 32'h0);
    tbl[4]  = mk(0, 0, 32'h0,        0, 32'h0,        1,   0, 32'h8,        1, 32'h0);
    tbl[5]  = mk(0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h8,        1, 32'h4);
    tbl[6]  = mk(0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h8,        0, 32'h0);
    tbl[7]  = mk(0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h8,        0, 32'h0);
    tbl[8]  = mk(1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h8,        0, 32'h0);
    tbl[9]  = mk(0, 1, 32'h8,        0, 32'h0,        1,   1, 32'hC,        0, 32'h0);
    tbl[10] = mk(0, 0, 32'h0,        0, 32'h0,        0,   1, 32'hC,        1, 32'h8);
    tbl[11] = mk(1, 0, 32'h0,        1, 32'hFFFF_FFFE, 1,  0, 32'hC,        0, 32'h0);
    tbl[12] = mk(1, 0, 32'h0,        0, 32'h0,        1,   1, 32'hFFFF_FFFC, 0, 32'h0);
    tbl[13] = mk(0, 1, 32'hFFFF_FFFC, 0, 32'h0,       1,   1, 32'h0,        0, 32'h0);
    tbl[14] = mk(0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0,        1, 32'hFFFF_FFFC);
    tbl[15] = mk(0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0,        0, 32'h0);
    tbl[16] = mk(1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0,        0, 32'h0);
    tbl[17] = mk(1, 0, 32'h0,        0, 32'h0,        1,   1, 32'h4,        0, 32'h0);
    tbl[18] = mk(1, 1, 32'h0,        1, 32'h0000_0100, 1,  0, 32'h8,        0, 32'h0);
    tbl[19] = mk(1, 1, 32'h4,        0, 32'h0,        1,   1, 32'h100,      0, 32'h0);
    tbl[20] = mk(0, 1, 32'h100,      0, 32'h0,        1,   1, 32'h104,      0, 32'h0);
    tbl[21] = mk(0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h104,      1, 32'h100);
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].g, tbl[i].rv, tbl[i].rd, tbl[i].rdir, tbl[i].tgt, tbl[i].rdy);
      chk($sformatf("vec%0d_req", i),   {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      chk($sformatf("vec%0d_addr", i),  imem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_valid", i), {31'b0, valid}, {31'b0, tbl[i].e_valid});
      chk($sformatf("vec%0d_pc", i),    pc, tbl[i].e_pc);
      chk($sformatf("vec%0d_instr", i), instr, tbl[i].e_instr);
    end
  endtask

  // Reference model: every fetch belongs to an epoch; a redirect opens a new
  // epoch and anything from an older epoch never reaches decode.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          cyc;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  pend_t       pend_q [$];
  ent_t        exp_q  [$];
  int          epoch;
  logic [31:0] fetch_pc;
  int          n_accept;

  task automatic run_random(input int n_cycles);
    logic        g, rv, rdir, rdy, e_req, e_valid;
    logic [31:0] rd, tgt;
    pend_t       p;
    pend_q.delete();
    exp_q.delete();
    epoch    = 0;
    fetch_pc = 32'h0;
    n_accept = 0;
    for (int i = 0; i < n_cycles; i++) begin
      g    = ($urandom_range(0, 3) != 0);
      rdy  = ($urandom_range(0, 3) != 0);
      rdir = ($urandom_range(0, 19) == 0);
      tgt  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : $urandom;
      rv   = (pend_q.size() > 0) && (pend_q[0].cyc < cyc + 1) && ($urandom_range(0, 2) != 0);
      rd   = rv ? mem_word(pend_q[0].addr) : $urandom;
      drive(g, rv, rd, rdir, tgt, rdy);

      e_req   = !rdir && ((pend_q.size() + exp_q.size()) < DEPTH);
      e_valid = !rdir && (exp_q.size() > 0);
      chk("rnd_req",   {31'b0, imem_req}, {31'b0, e_req});
      if (e_req) chk("rnd_addr", imem_addr, fetch_pc);
      chk("rnd_valid", {31'b0, valid}, {31'b0, e_valid});
      if (e_valid) begin
        chk("rnd_pc",    pc, exp_q[0].pc);
        chk("rnd_instr", instr, exp_q[0].instr);
      end else begin
        chk("rnd_nop", instr, NOP);
        chk("rnd_pc0", pc, 32'h0);
      end

      // Advance the model across the coming rising edge.
      if (e_valid && rdy) begin
        void'(exp_q.pop_front());
        n_accept++;
      end
      if (rv) begin
        p = pend_q.pop_front();
        if (!rdir && p.epoch == epoch) exp_q.push_back('{pc: p.addr, instr: rd});
      end
      if (e_req && g) begin
        pend_q.push_back('{addr: fetch_pc, epoch: epoch, cyc: cyc});
        fetch_pc = fetch_pc + 32'd4;
      end
      if (rdir) begin
        epoch++;
        exp_q.delete();
        fetch_pc = {tgt[31:2], 2'b00};
      end
    end
  endtask

  // Test sequence and final report
  initial begin
    rst_n = 1'b0;
    idle_inputs();
    do_reset();
    run_table();

    do_reset();
    run_random(3000);
    chk("rnd_liveness", {31'b0, (n_accept >= 200)}, 32'h1);

    // Asynchronous reset in the middle of a cycle clears state at once.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req",   {31'b0, imem_req}, 32'h0);
    chk("async_rst_addr",  imem_addr, 32'h0);
    chk("async_rst_valid", {31'b0, valid}, 32'h0);
    chk("async_rst_instr", instr, NOP);
    chk("async_rst_pc",    pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
